mul_div_unit: RTL

Multi-cycle multiply/divide unit with private HI/LO registers, living in the E stage of the five-stage pipeline. It consumes the forwarded E-stage operands (rs/rt) and a decoded MDU type. It produces the mfhi/mflo result for the M pipeline register, plus start/busy for the stall unit. Multiply-class operations hold busy for 5 cycles and divide-class for 10, matching the pipeline's stall contract.

---
 rtl/mul_div_unit_pkg.sv | 37 +++
 rtl/mul_div_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared MDU op codes, FSM states and op-class decode for mul_div_unit.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU codes 9/10).
package mul_div_unit_pkg;

  typedef enum logic [4:0] {
    MDU_NONE  = 5'd0,
    MDU_MULT  = 5'd1,
    MDU_MULTU = 5'd2,
    MDU_DIV   = 5'd3,
    MDU_DIVU  = 5'd4,
    MDU_MFHI  = 5'd5,
    MDU_MFLO  = 5'd6,
    MDU_MTHI  = 5'd7,
    MDU_MTLO  = 5'd8,
    MDU_MADD  = 5'd9,
    MDU_MADDU = 5'd10
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [4:0] op);
`ifdef MDU_MADD_EN
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_MADD) || (op == MDU_MADDU);
`else
    return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO; MUL_CYCLES/DIV_CYCLES busy, commit on last busy edge.
// No backpressure: the stall unit must hold off new MDU ops while busy; starts/moves during busy are ignored.
// Optional feature macro: MDU_MADD_EN.
import mul_div_unit_pkg::*;

module mul_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  MDUType,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] MDUO,
  output logic        start,
  output logic        busy
);

  mdu_state_e  state, state_nxt;
  logic [31:0] hi, lo, tmp_hi, tmp_lo;
  logic        tmp_vld;
  logic [3:0]  cnt;
  logic        mul_op, div_op;
  logic [63:0] prod_s, prod_u, res;
  logic        res_vld;
  logic [31:0] quo, rem;
  logic [3:0]  lat;

  assign mul_op = is_mul_op(MDUType);
  assign div_op = is_div_op(MDUType);
  assign lat    = div_op ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'b0, A} * {32'b0, B};

  always_comb begin
    quo = '0;
    rem = '0;
    if (B != 32'd0) begin
      if (MDUType == MDU_DIV) begin
        quo = $signed(A) / $signed(B);
        rem = $signed(A) % $signed(B);
      end else begin
        quo = A / B;
        rem = A % B;
      end
    end
  end

  always_comb begin
    res     = prod_s;
    res_vld = 1'b1;
    case (MDUType)
      MDU_MULTU: res = prod_u;
      MDU_DIV, MDU_DIVU: begin
        res     = {rem, quo};
        res_vld = (B != 32'd0);
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  res = {hi, lo} + prod_s;
      MDU_MADDU: res = {hi, lo} + prod_u;
`endif
      default: ;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_BUSY;
      S_BUSY: if (cnt <= 4'd1) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy  = (state == S_BUSY);
    start = mul_op | div_op;
    MDUO  = '0;
    if (MDUType == MDU_MFHI)      MDUO = hi;
    else if (MDUType == MDU_MFLO) MDUO = lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      tmp_hi  <= '0;
      tmp_lo  <= '0;
      tmp_vld <= 1'b0;
      cnt     <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        {tmp_hi, tmp_lo} <= res;
        tmp_vld          <= res_vld;
        cnt              <= lat;
      end else if (MDUType == MDU_MTHI) begin
        hi <= A;
      end else if (MDUType == MDU_MTLO) begin
        lo <= A;
      end
    end else begin
      cnt <= cnt - 4'd1;
      // Divide-by-zero leaves tmp_vld low so HI/LO keep their old values.
      if (cnt <= 4'd1 && tmp_vld) begin
        hi <= tmp_hi;
        lo <= tmp_lo;
      end
    end
  end

endmodule
